mau_reliable_send_match_unit: RTL
=================================

Name: mau_reliable_send_match_unit

Overview:
- Stage directly upstream of the reliable-send action unit.
- Looks up each PHV's flow key in a direct-mapped flow table (tag RAM plus flowstate RAM, 2^ADDR_WIDTH entries).
- Presents hit, flowstate, flow address and a 2-bit forwarding select alongside the registered PHV.
- Writes back the flowstate the action unit broadcasts, and installs new flows on DAT misses.

Parameters:
- PHV_WIDTH, 456, PHV bus width
- PHV_B_COUNT, 9, byte containers
- PHV_H_COUNT, 2, halfword containers
- PHV_W_COUNT, 11, word containers
- FLOWSTATE_WIDTH, 32, flowstate (RPN) width
- ADDR_WIDTH, 10, flow table index width
- KEY_W_INDEX, 0, phv_w container holding the 32-bit flow key

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- reliable_enable  in  1  0 = force miss, no installs
- s_phv_info  in  PHV_WIDTH  input PHV
- s_phv_valid  in  1  input valid
- s_phv_ready  out  1  input ready
- m_phv_info  out  PHV_WIDTH  registered PHV
- m_phv_valid  out  1  output valid
- m_phv_ready  in  1  output ready
- m_phv_mat_hit  out  1  flow table hit
- m_phv_mat_value  out  FLOWSTATE_WIDTH  flowstate read from RAM
- m_phv_mat_addr  out  ADDR_WIDTH  flow index
- m_phv_match_sel  out  2  forwarding select: 00 RAM, 01 newest, 10 second, 11 third
- bcd_flowstate_in  in  FLOWSTATE_WIDTH  broadcast flowstate
- bcd_addr_in  in  ADDR_WIDTH  broadcast address
- bcd_valid_in  in  1  broadcast write strobe
- stat_hit_cnt  out  32  hit counter (optional feature)
- stat_miss_cnt  out  32  miss counter (optional feature)

Behaviour:
- Key decode
  - key = phv_w[KEY_W_INDEX]; index = key[ADDR_WIDTH-1:0]; tag = key[31:ADDR_WIDTH].
  - "Eligible" = phv_b[1][7] (send-table mask) AND reliable_enable.
  - "DAT" = phv_b[0][2].
- Handshake and latency
  - s_phv_ready = ~m_phv_valid | m_phv_ready. Latency is exactly 1 cycle.
  - On accept: register PHV, index and tag; set m_phv_valid.
  - m_phv_valid clears on m_phv_ready when there is no new accept.
- RAM reads
  - Tag RAM, valid-bit register array and flowstate RAM are read every cycle.
  - Read address = incoming index on accept, otherwise the held index. During a stall the outputs therefore track write-backs.
- Hit and address outputs
  - m_phv_mat_hit = eligible_held & valid[idx] & (tag_q == tag_held).
  - m_phv_mat_addr = held index.
- Write-back and install
  - bcd_valid_in writes bcd_flowstate_in to flowstate[bcd_addr_in].
  - Install fires on output handshake when held PHV is eligible, DAT and miss: write tag, set valid[idx], write flowstate[idx] = 0. Install wins over a bcd write to the same address in the same cycle.
  - Both RAMs are write-first: a same-cycle write to the read address is bypassed into next-cycle data.
- Forwarding history
  - 3-entry shift register of {valid, addr}, shifted on every output handshake.
  - Entry valid = handshaked PHV was eligible & DAT (hit or installed).
  - If hit: match_sel = 01 if hist0 matches idx, else 10 if hist1 matches, else 11 if hist2 matches, else 00. Youngest entry has priority.
  - If miss: match_sel = 00.
- Reset (async, rst_n low)
  - m_phv_valid = 0; all history valids = 0; all table valid bits = 0; counters = 0.
  - m_phv_info, m_phv_mat_* = 0.
  - RAM contents are not reset. A reset mid-transfer drops the in-flight PHV.

Optional Feature:
- Macro RELI_MATCH_STATS_EN.
- Defined: on each output handshake with eligible PHV, stat_hit_cnt or stat_miss_cnt increments by 1, wrapping at 2^32.
- Undefined: both ports tied to 0 and no counter registers exist.

Decomposition:
- Package mau_reliable_send_pkg: PHV container indices (PKT_PROPERTY_ON=0, PKT_VALID_ON=1), bit positions (DAT_INDEX=2, NACK_INDEX=3, SEND_TABLE_MASK=7), match_sel encodings.
- One sub-module: reli_flow_table_ram, a parameterised single-clock write-first simple-dual-port RAM, instantiated for tags and flowstate.

Test Plan:
- Cold table, eligible DAT key 0x0000_0405 → hit=0, sel=00, addr=0x005. After handshake, valid[5]=1 and flowstate[5]=0.
- Same key repeated back-to-back → second PHV hit=1, sel=01. Third PHV sel=01, hist1 also valid.
- Keys A, B, C, A (distinct indices, all installed) → fourth PHV sel=11. A, B, C, D, A → fifth PHV sel=00 and value = RAM.
- Hold m_phv_ready=0 with output at idx 5, pulse bcd_valid_in addr 5 value 0x77 → m_phv_mat_value becomes 0x77 next cycle; PHV and sel unchanged.
- reliable_enable=0 with installed key → hit=0, no install, PHV passes unchanged. Then assert rst_n=0 mid-stall → m_phv_valid=0 immediately and the same key misses afterwards.
- With RELI_MATCH_STATS_EN: 3 hits and 2 misses → stat_hit_cnt=3, stat_miss_cnt=2.

Source files
------------

// File: rtl/mau_reliable_send_pkg.sv
// ---------------------------------------------------------------------------
// mau_reliable_send_pkg
// Shared constants for the reliable-send match stage:
//   - PHV container indices and bit positions used for key/flag decode
//   - forwarding-select encodings presented on m_phv_match_sel
//   - pick_match_sel(): youngest-first selection over the history matches
// ---------------------------------------------------------------------------
package mau_reliable_send_pkg;

  // phv_b container indices
  localparam int PKT_PROPERTY_ON = 0;
  localparam int PKT_VALID_ON    = 1;

  // Bit positions inside those byte containers
  localparam int DAT_INDEX       = 2;
  localparam int NACK_INDEX      = 3;
  localparam int SEND_TABLE_MASK = 7;

  // Forwarding select: where the action unit should take the flowstate from
  typedef enum logic [1:0] {
    SEL_RAM    = 2'b00,
    SEL_NEWEST = 2'b01,
    SEL_SECOND = 2'b10,
    SEL_THIRD  = 2'b11
  } match_sel_e;

  // hist_match[0] is the youngest history entry and has priority
  function automatic match_sel_e pick_match_sel(input logic hit, input logic [2:0] hist_match);
    if (!hit)               return SEL_RAM;
    else if (hist_match[0]) return SEL_NEWEST;
    else if (hist_match[1]) return SEL_SECOND;
    else if (hist_match[2]) return SEL_THIRD;
    else                    return SEL_RAM;
  endfunction

endpackage

// File: rtl/reli_flow_table_ram.sv
// ---------------------------------------------------------------------------
// reli_flow_table_ram
// Single-clock simple-dual-port RAM, write-first: a write to the address being
// read in the same cycle is returned as next-cycle read data.
// Ports:
//   clk, rst_n      clock / async active-low reset (read register only)
//   i_we, i_waddr, i_wdata   write port
//   i_raddr         read address, sampled every cycle
//   o_rdata         registered read data
// ---------------------------------------------------------------------------
module reli_flow_table_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Storage array write (contents are never reset)
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read with same-cycle write bypass
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           r_rdata <= '0;
    else if (i_we && (i_waddr == i_raddr)) r_rdata <= i_wdata;
    else                                  r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mau_reliable_send_match_unit.sv
// ---------------------------------------------------------------------------
// mau_reliable_send_match_unit
// Direct-mapped flow-table lookup in front of the reliable-send action unit.
// PHV layout (LSB first): phv_b[0..B-1] (8b), phv_h[0..H-1] (16b),
// phv_w[0..W-1] (32b). Flow key = phv_w[KEY_W_INDEX].
// Ports:
//   s_phv_*            input PHV stream (valid/ready)
//   m_phv_*            registered PHV plus lookup results (1-cycle latency)
//   bcd_*              flowstate write-back broadcast from the action unit
//   reliable_enable    0 forces misses and suppresses installs
//   stat_hit_cnt/stat_miss_cnt  counters, present only with RELI_MATCH_STATS_EN
// ---------------------------------------------------------------------------
module mau_reliable_send_match_unit
  import mau_reliable_send_pkg::*;
#(
  parameter int PHV_WIDTH       = 456,
  parameter int PHV_B_COUNT     = 9,
  parameter int PHV_H_COUNT     = 2,
  parameter int PHV_W_COUNT     = 11,
  parameter int FLOWSTATE_WIDTH = 32,
  parameter int ADDR_WIDTH      = 10,
  parameter int KEY_W_INDEX     = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       reliable_enable,
  input  logic [PHV_WIDTH-1:0]       s_phv_info,
  input  logic                       s_phv_valid,
  output logic                       s_phv_ready,
  output logic [PHV_WIDTH-1:0]       m_phv_info,
  output logic                       m_phv_valid,
  input  logic                       m_phv_ready,
  output logic                       m_phv_mat_hit,
  output logic [FLOWSTATE_WIDTH-1:0] m_phv_mat_value,
  output logic [ADDR_WIDTH-1:0]      m_phv_mat_addr,
  output logic [1:0]                 m_phv_match_sel,
  input  logic [FLOWSTATE_WIDTH-1:0] bcd_flowstate_in,
  input  logic [ADDR_WIDTH-1:0]      bcd_addr_in,
  input  logic                       bcd_valid_in,
  output logic [31:0]                stat_hit_cnt,
  output logic [31:0]                stat_miss_cnt
);

  localparam int TAG_WIDTH = 32 - ADDR_WIDTH;
  localparam int W_BASE    = PHV_B_COUNT*8 + PHV_H_COUNT*16 + KEY_W_INDEX*32;

  logic [31:0]            w_key;
  logic [ADDR_WIDTH-1:0]  w_in_idx, w_rd_addr;
  logic [TAG_WIDTH-1:0]   w_in_tag, w_tag_q;
  logic                   w_in_elig, w_accept, w_out_hs, w_hit, w_install, w_dat;
  logic [FLOWSTATE_WIDTH-1:0] w_fs_q;
  logic [2:0]             w_hist_match;

  logic                   r_out_valid, r_elig;
  logic [PHV_WIDTH-1:0]   r_phv;
  logic [ADDR_WIDTH-1:0]  r_idx;
  logic [TAG_WIDTH-1:0]   r_tag;
  logic [(1<<ADDR_WIDTH)-1:0] r_tbl_valid, r_tbl_zero;
  logic                   r_valid_q, r_zero_q;
  logic [2:0]             r_hist_vld;
  logic [ADDR_WIDTH-1:0]  r_hist_addr [3];

  assign w_key     = s_phv_info[W_BASE +: 32];
  assign w_in_idx  = w_key[ADDR_WIDTH-1:0];
  assign w_in_tag  = w_key[31:ADDR_WIDTH];
  assign w_in_elig = s_phv_info[PKT_VALID_ON*8 + SEND_TABLE_MASK] & reliable_enable;
  assign w_dat     = r_phv[PKT_PROPERTY_ON*8 + DAT_INDEX];

  assign s_phv_ready = ~r_out_valid | m_phv_ready;
  assign w_accept    = s_phv_valid & s_phv_ready;
  assign w_out_hs    = r_out_valid & m_phv_ready;
  // While stalled the held index keeps being re-read so write-backs show up
  assign w_rd_addr   = w_accept ? w_in_idx : r_idx;

  assign w_hit     = r_elig & r_valid_q & (w_tag_q == r_tag);
  assign w_install = w_out_hs & r_elig & w_dat & ~w_hit;

  // Pipeline register: PHV, decoded index/tag and eligibility
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_phv       <= '0;
      r_idx       <= '0;
      r_tag       <= '0;
      r_elig      <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_phv       <= s_phv_info;
      r_idx       <= w_in_idx;
      r_tag       <= w_in_tag;
      r_elig      <= w_in_elig;
    end else if (w_out_hs) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  reli_flow_table_ram #(.DATA_WIDTH(TAG_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_tag_ram (
    .clk(clk), .rst_n(rst_n), .i_we(w_install), .i_waddr(r_idx), .i_wdata(r_tag),
    .i_raddr(w_rd_addr), .o_rdata(w_tag_q)
  );

  // The flowstate RAM carries only broadcast writes. An install's "write 0" is
  // recorded in r_tbl_zero instead, so an install and a broadcast to different
  // addresses in the same cycle both take effect.
  reli_flow_table_ram #(.DATA_WIDTH(FLOWSTATE_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_fs_ram (
    .clk(clk), .rst_n(rst_n), .i_we(bcd_valid_in), .i_waddr(bcd_addr_in),
    .i_wdata(bcd_flowstate_in), .i_raddr(w_rd_addr), .o_rdata(w_fs_q)
  );

  // Per-entry valid and "installed, not yet written back" bits, read write-first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tbl_valid <= '0;
      r_tbl_zero  <= '0;
      r_valid_q   <= 1'b0;
      r_zero_q    <= 1'b0;
    end else begin
      if (w_install) begin
        r_tbl_valid[r_idx] <= 1'b1;
        r_tbl_zero[r_idx]  <= 1'b1;
      end
      // Install wins over a broadcast to the same entry
      if (bcd_valid_in && !(w_install && (bcd_addr_in == r_idx))) begin
        r_tbl_zero[bcd_addr_in] <= 1'b0;
      end
      r_valid_q <= (w_install && (r_idx == w_rd_addr)) | r_tbl_valid[w_rd_addr];
      if (w_install && (r_idx == w_rd_addr))              r_zero_q <= 1'b1;
      else if (bcd_valid_in && (bcd_addr_in == w_rd_addr)) r_zero_q <= 1'b0;
      else                                                r_zero_q <= r_tbl_zero[w_rd_addr];
    end
  end

  // Forwarding history: {eligible & DAT, index} of the last three handshakes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist_vld  <= 3'b000;
      r_hist_addr <= '{default: '0};
    end else if (w_out_hs) begin
      r_hist_vld     <= {r_hist_vld[1:0], r_elig & w_dat};
      r_hist_addr[2] <= r_hist_addr[1];
      r_hist_addr[1] <= r_hist_addr[0];
      r_hist_addr[0] <= r_idx;
    end else begin
      r_hist_vld <= r_hist_vld;
    end
  end

  assign w_hist_match[0] = r_hist_vld[0] & (r_hist_addr[0] == r_idx);
  assign w_hist_match[1] = r_hist_vld[1] & (r_hist_addr[1] == r_idx);
  assign w_hist_match[2] = r_hist_vld[2] & (r_hist_addr[2] == r_idx);

  assign m_phv_info      = r_phv;
  assign m_phv_valid     = r_out_valid;
  assign m_phv_mat_hit   = w_hit;
  assign m_phv_mat_addr  = r_idx;
  assign m_phv_mat_value = r_zero_q ? '0 : w_fs_q;
  assign m_phv_match_sel = pick_match_sel(w_hit, w_hist_match);

`ifdef RELI_MATCH_STATS_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;

  // Hit/miss counters for eligible PHVs leaving the stage (wrap naturally)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt  <= 32'd0;
      r_miss_cnt <= 32'd0;
    end else if (w_out_hs && r_elig) begin
      if (w_hit) r_hit_cnt  <= r_hit_cnt + 32'd1;
      else       r_miss_cnt <= r_miss_cnt + 32'd1;
    end else begin
      r_hit_cnt <= r_hit_cnt;
    end
  end

  assign stat_hit_cnt  = r_hit_cnt;
  assign stat_miss_cnt = r_miss_cnt;
`else
  assign stat_hit_cnt  = 32'd0;
  assign stat_miss_cnt = 32'd0;
`endif

endmodule
